// File: rtl/brom_bus_arbiter.sv
// brom_bus_arbiter: shares one single-port boot ROM between an instruction-fetch master (A)
// and a data-load master (B), one ROM access per grant, with round-robin fairness and a timeout guard.
module brom_bus_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_a_request,
    input  logic [31:0] i_a_address,
    output logic [31:0] o_a_rdata,
    output logic        o_a_ready,
    input  logic        i_b_request,
    input  logic [31:0] i_b_address,
    output logic [31:0] o_b_rdata,
    output logic        o_b_ready,
    output logic        o_rom_request,
    output logic [31:0] o_rom_address,
    input  logic [31:0] i_rom_rdata,
    input  logic        i_rom_ready,
    output logic        o_error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_A,
        S_GRANT_B,
        S_RELEASE_A,
        S_RELEASE_B
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_last_b;
    logic        w_rr;
    logic        w_pick_b;
    logic        w_serve_b;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_done_data;

    assign w_rr        = (ROUND_ROBIN != 0);
    assign w_pick_b    = i_b_request & (~i_a_request | (w_rr & ~r_last_b));
    assign w_serve_b   = (r_state == S_GRANT_B);
    assign w_timeout   = (r_count == LP_LAST);
    assign w_done      = i_rom_ready | w_timeout;
    assign w_done_data = i_rom_ready ? i_rom_rdata : 32'd0;

    // Arbitration FSM: select in IDLE, wait for the ROM (or give up) in GRANT, hold until the owner drops in RELEASE.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_count       <= 8'd0;
            r_last_b      <= 1'b1;
            o_a_rdata     <= 32'd0;
            o_a_ready     <= 1'b0;
            o_b_rdata     <= 32'd0;
            o_b_ready     <= 1'b0;
            o_rom_request <= 1'b0;
            o_rom_address <= 32'd0;
            o_error       <= 1'b0;
        end else begin
            o_rom_request <= 1'b0;
            o_a_ready     <= 1'b0;
            o_b_ready     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_a_request | i_b_request) begin
                        o_rom_request <= 1'b1;
                        o_rom_address <= w_pick_b ? i_b_address : i_a_address;
                        r_state       <= w_pick_b ? S_GRANT_B : S_GRANT_A;
                        r_count       <= 8'd0;
                    end
                end
                S_GRANT_A, S_GRANT_B: begin
                    if (w_done) begin
                        if (w_serve_b) begin
                            o_b_rdata <= w_done_data;
                            o_b_ready <= 1'b1;
                            r_state   <= S_RELEASE_B;
                        end else begin
                            o_a_rdata <= w_done_data;
                            o_a_ready <= 1'b1;
                            r_state   <= S_RELEASE_A;
                        end
                        if (i_rom_ready) r_last_b <= w_serve_b;
                        else o_error <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_RELEASE_A: if (!i_a_request) r_state <= S_IDLE;
                S_RELEASE_B: if (!i_b_request) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brom_bus_arbiter.sv
// tb_brom_bus_arbiter: two arbiters (round-robin/TIMEOUT=15 and fixed-priority/TIMEOUT=4) driven by
// master agents and ROM stubs, compared each cycle against a transaction-level reference model.
module tb_brom_bus_arbiter;
    localparam int TO0 = 15;
    localparam int TO1 = 4;
    localparam logic [31:0] WORD1 = 32'h1234_5678;

    logic        i_clock   = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        req       [2][2];
    logic [31:0] addr      [2][2];
    logic [31:0] rdata     [2][2];
    logic        rdy       [2][2];
    logic        rom_req   [2];
    logic [31:0] rom_addr  [2];
    logic [31:0] rom_rdata [2];
    logic        rom_rdy   [2];
    logic        err       [2];

    always #5 i_clock = ~i_clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        brom_bus_arbiter #(.ROUND_ROBIN(g == 0 ? 1 : 0), .TIMEOUT(g == 0 ? TO0 : TO1)) u_dut (
            .i_clock      (i_clock),
            .i_reset_n    (i_reset_n),
            .i_a_request  (req[g][0]),
            .i_a_address  (addr[g][0]),
            .o_a_rdata    (rdata[g][0]),
            .o_a_ready    (rdy[g][0]),
            .i_b_request  (req[g][1]),
            .i_b_address  (addr[g][1]),
            .o_b_rdata    (rdata[g][1]),
            .o_b_ready    (rdy[g][1]),
            .o_rom_request(rom_req[g]),
            .o_rom_address(rom_addr[g]),
            .i_rom_rdata  (rom_rdata[g]),
            .i_rom_ready  (rom_rdy[g]),
            .o_error      (err[g])
        );
    end

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] mem [16];
    int          to_c [2] = '{TO0, TO1};
    bit          rr_c [2] = '{1'b1, 1'b0};
    int          rate [2][2];
    bit          mute, glitch, abandon;
    int          dmax;
    int          pend [2];
    logic [31:0] paddr [2];
    int          log0[$];
    int          log1[$];

    // reference model: one outstanding access per arbiter, described by owner, start cycle and release wait
    bit          m_busy [2];
    bit          m_hold [2];
    bit          m_own  [2];
    bit          m_last [2];
    bit          m_err  [2];
    int          m_start[2];
    bit          e_req  [2];
    logic [31:0] e_addr [2];
    bit          e_rdy  [2][2];
    logic [31:0] e_data [2][2];
    logic        s_req  [2][2];
    logic [31:0] s_addr [2][2];
    logic        s_rr   [2];
    logic [31:0] s_rd   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_hold[i] = 0; m_own[i] = 0; m_last[i] = 1; m_err[i] = 0;
            e_req[i] = 0; e_addr[i] = 0;
            for (int m = 0; m < 2; m++) begin
                e_rdy[i][m] = 0; e_data[i][m] = 0;
            end
        end
    endtask

    task automatic model_step(input int i);
        e_req[i] = 0; e_rdy[i][0] = 0; e_rdy[i][1] = 0;
        if (m_busy[i]) begin
            if (s_rr[i] || cyc - m_start[i] == to_c[i]) begin
                e_rdy[i][m_own[i]]  = 1;
                e_data[i][m_own[i]] = s_rr[i] ? s_rd[i] : 32'd0;
                if (s_rr[i]) m_last[i] = m_own[i];
                else m_err[i] = 1;
                m_busy[i] = 0; m_hold[i] = 1;
            end
        end else if (m_hold[i]) begin
            if (!s_req[i][m_own[i]]) m_hold[i] = 0;
        end else if (s_req[i][0] || s_req[i][1]) begin
            m_own[i]   = s_req[i][1] && (!s_req[i][0] || (rr_c[i] && !m_last[i]));
            e_req[i]   = 1;
            e_addr[i]  = s_addr[i][m_own[i]];
            m_busy[i]  = 1;
            m_start[i] = cyc;
        end
    endtask

    task automatic compare(input int i);
        check($sformatf("rom_req[%0d]", i), 32'(rom_req[i]), 32'(e_req[i]));
        if (e_req[i]) check($sformatf("rom_addr[%0d]", i), rom_addr[i], e_addr[i]);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("ready[%0d][%0d]", i, m), 32'(rdy[i][m]), 32'(e_rdy[i][m]));
            check($sformatf("rdata[%0d][%0d]", i, m), rdata[i][m], e_data[i][m]);
        end
        check($sformatf("error[%0d]", i), 32'(err[i]), 32'(m_err[i]));
        check($sformatf("excl[%0d]", i), 32'(rdy[i][0] & rdy[i][1]), 32'd0);
    endtask

    task automatic react(input int i);
        for (int m = 0; m < 2; m++)
            if (rdy[i][m]) begin
                if (i == 0) log0.push_back(m);
                else log1.push_back(m);
            end
        rom_rdy[i] = 1'b0;
        if (pend[i] > 0) begin
            pend[i]--;
            if (pend[i] == 0) begin
                rom_rdy[i]   = 1'b1;
                rom_rdata[i] = mem[paddr[i][5:2]];
            end
        end else if (glitch && $urandom_range(7) == 0) begin
            rom_rdy[i]   = 1'b1;
            rom_rdata[i] = $urandom;
        end
        if (rom_req[i] && !mute) begin
            pend[i]  = $urandom_range(dmax, 1);
            paddr[i] = rom_addr[i];
        end
        for (int m = 0; m < 2; m++) begin
            if (req[i][m] && rdy[i][m]) req[i][m] = 1'b0;
            else if (req[i][m] && abandon && $urandom_range(31) == 0) req[i][m] = 1'b0;
            else if (!req[i][m] && int'($urandom_range(99)) < rate[i][m]) begin
                req[i][m]  = 1'b1;
                addr[i][m] = $urandom & 32'hFFFF_FFFC;
            end
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                s_req[i][m]  = req[i][m];
                s_addr[i][m] = addr[i][m];
            end
            s_rr[i] = rom_rdy[i];
            s_rd[i] = rom_rdata[i];
        end
        @(posedge i_clock);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) compare(i);
        for (int i = 0; i < 2; i++) react(i);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rom_req[%0d]", i), 32'(rom_req[i]), 32'd0);
            check($sformatf("rst_rom_addr[%0d]", i), rom_addr[i], 32'd0);
            check($sformatf("rst_error[%0d]", i), 32'(err[i]), 32'd0);
            for (int m = 0; m < 2; m++) begin
                check($sformatf("rst_ready[%0d][%0d]", i, m), 32'(rdy[i][m]), 32'd0);
                check($sformatf("rst_rdata[%0d][%0d]", i, m), rdata[i][m], 32'd0);
            end
            pend[i] = 0; rom_rdy[i] = 1'b0; rom_rdata[i] = 32'd0;
            req[i][0] = 1'b0; req[i][1] = 1'b0;
        end
        model_reset();
        @(posedge i_clock);
        @(posedge i_clock);
        #2;
        i_reset_n = 1'b1;
    endtask

    task automatic run_until_ready(input int m, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int k = 1; k <= 60 && (n0 == 0 || n1 == 0); k++) begin
            tick();
            if (n0 == 0 && rdy[0][m]) n0 = k;
            if (n1 == 0 && rdy[1][m]) n1 = k;
        end
    endtask

    task automatic raise(input int m, input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            req[i][m]  = 1'b1;
            addr[i][m] = a;
        end
    endtask

    function automatic int count_b(input int i);
        int c = 0;
        if (i == 0) foreach (log0[k]) c += log0[k];
        else foreach (log1[k]) c += log1[k];
        return c;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b0; addr[i][m] = 32'd0; rate[i][m] = 0;
            end
            rom_rdy[i] = 1'b0; rom_rdata[i] = 32'd0; pend[i] = 0; paddr[i] = 32'd0;
        end
        foreach (mem[k]) mem[k] = $urandom | 32'h1;
        mem[1] = WORD1;
        mute = 0; glitch = 0; abandon = 0; dmax = 1;
        model_reset();
        #2;
        do_reset();

        // single A read of word 1
        raise(0, 32'h4);
        run_until_ready(0, n0, n1);
        check("t1_latency0", 32'(n0), 32'd3);
        check("t1_latency1", 32'(n1), 32'd3);
        check("t1_data0", rdata[0][0], WORD1);
        check("t1_data1", rdata[1][0], WORD1);
        repeat (3) tick();

        // simultaneous requests after reset: A first, then B
        do_reset();
        log0.delete(); log1.delete();
        raise(0, 32'h0);
        raise(1, 32'h8);
        repeat (16) tick();
        check("t2_count0", 32'(log0.size()), 32'd2);
        check("t2_count1", 32'(log1.size()), 32'd2);
        check("t2_first0", 32'(log0.size() > 0 ? log0[0] : -1), 32'd0);
        check("t2_first1", 32'(log1.size() > 0 ? log1[0] : -1), 32'd0);
        check("t2_bdata0", rdata[0][1], mem[2]);
        check("t2_adata0", rdata[0][0], mem[0]);

        // continuous contention: alternation vs fixed priority
        log0.delete(); log1.delete();
        for (int i = 0; i < 2; i++) for (int m = 0; m < 2; m++) rate[i][m] = 100;
        repeat (40) tick();
        check("t3_count", 32'(log0.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_seq%0d", k), 32'(k < log0.size() ? log0[k] : -1), 32'(k % 2));
        check("t4_count", 32'(log1.size() >= 6), 32'd1);
        check("t4_no_b", 32'(count_b(1)), 32'd0);
        for (int i = 0; i < 2; i++) for (int m = 0; m < 2; m++) rate[i][m] = 0;
        repeat (25) tick();

        // ROM never answers: timeout, zero data, sticky error
        mute = 1;
        raise(0, $urandom & 32'hFFFF_FFFC);
        run_until_ready(0, n0, n1);
        check("t5_latency0", 32'(n0), 32'(TO0 + 1));
        check("t5_latency1", 32'(n1), 32'(TO1 + 1));
        check("t5_data0", rdata[0][0], 32'd0);
        check("t5_data1", rdata[1][0], 32'd0);
        check("t5_error0", 32'(err[0]), 32'd1);
        mute = 0;
        repeat (3) tick();
        raise(0, 32'h4);
        run_until_ready(0, n0, n1);
        check("t5_after_data0", rdata[0][0], WORD1);
        check("t5_sticky0", 32'(err[0]), 32'd1);
        check("t5_sticky1", 32'(err[1]), 32'd1);
        repeat (3) tick();

        // reset in the middle of a B grant, then a stale ROM ready
        raise(1, 32'hC);
        tick();
        tick();
        log0.delete(); log1.delete();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rom_rdy[i]   = 1'b1;
            rom_rdata[i] = 32'hDEAD_BEEF;
        end
        raise(0, 32'h4);
        run_until_ready(0, n0, n1);
        check("t6_latency0", 32'(n0), 32'd3);
        check("t6_latency1", 32'(n1), 32'd3);
        check("t6_data0", rdata[0][0], WORD1);
        check("t6_no_b0", 32'(count_b(0)), 32'd0);
        check("t6_no_b1", 32'(count_b(1)), 32'd0);
        repeat (3) tick();

        // randomized traffic: variable ROM latency, stale/spurious readies, dropped requests
        glitch = 1; abandon = 1; dmax = 6;
        for (int k = 0; k < 2000; k++) begin
            if (k % 200 == 0) begin
                for (int i = 0; i < 2; i++) for (int m = 0; m < 2; m++) rate[i][m] = $urandom_range(60);
                mute = ($urandom_range(9) == 0);
            end
            if (k == 1000) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
